multi_target_tracker: RTL

Parametrised multi-target successor to the single-target tracker stage. It holds up to NUM_TRACKS independent tracks and associates each cleaned (x,y,z) measurement with the nearest predicted track inside a gate, or opens a new track. Each track carries a signed velocity and a saturating linear prediction, and tracks that miss too many frames are dropped. It sits between the coordinate-cleaning stage and downstream engagement logic, gated by lock_active from lock_fsm.

---
 rtl/multi_target_tracker.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_target_tracker.sv
// -----------------------------------------------------------------------------
// multi_target_tracker
//   Holds up to NUM_TRACKS tracks. Each accepted (x,y,z) measurement is matched
//   to the nearest predicted track within GATE (Chebyshev distance), or opens a
//   new track in the lowest free slot. Each track keeps a signed velocity and a
//   saturating one-step linear prediction. Tracks that miss MISS_LIMIT
//   consecutive frames are dropped. Low lock_active flushes every track.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   lock_active                  acceptance enable, low flushes all tracks
//   frame_tick                   single-cycle frame boundary pulse
//   x_in, y_in, z_in, in_valid   measurement; in_ready accepts it
//   out_valid / out_ready        track report handshake
//   trk_id                       slot of the reported track
//   x_curr, y_curr, z_curr       updated position
//   x_pred, y_pred, z_pred       predicted next position
//   new_track                    report is a freshly allocated track
//   target_moving                |velocity| >= VELOCITY_THRESHOLD on any axis
//   active_mask                  registered per-slot valid bits
//   overflow                     one-cycle pulse: measurement dropped, no slot
// -----------------------------------------------------------------------------
module multi_target_tracker #(
  parameter int                 COORD_W            = 16,
  parameter int                 NUM_TRACKS         = 4,
  parameter int                 ID_W               = 2,
  parameter logic [COORD_W-1:0] GATE               = 16'd8,
  parameter logic [COORD_W-1:0] VELOCITY_THRESHOLD = 16'd2,
  parameter int                 MISS_LIMIT         = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lock_active,
  input  logic                  frame_tick,
  input  logic [COORD_W-1:0]    x_in,
  input  logic [COORD_W-1:0]    y_in,
  input  logic [COORD_W-1:0]    z_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       trk_id,
  output logic [COORD_W-1:0]    x_curr,
  output logic [COORD_W-1:0]    y_curr,
  output logic [COORD_W-1:0]    z_curr,
  output logic [COORD_W-1:0]    x_pred,
  output logic [COORD_W-1:0]    y_pred,
  output logic [COORD_W-1:0]    z_pred,
  output logic                  new_track,
  output logic                  target_moving,
  output logic [NUM_TRACKS-1:0] active_mask,
  output logic                  overflow
);

  localparam int VEL_W  = COORD_W + 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(NUM_TRACKS - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, TICK, FLUSH, SEARCH, UPDATE, REPORT} state_t;

  state_t state, state_nxt;

  // Slot storage
  logic [NUM_TRACKS-1:0]    slot_valid;
  logic [NUM_TRACKS-1:0]    slot_hit;
  logic [MISS_W-1:0]        miss [NUM_TRACKS];
  logic [COORD_W-1:0]       pos  [NUM_TRACKS][3];
  logic [COORD_W-1:0]       pred [NUM_TRACKS][3];
  logic signed [VEL_W-1:0]  vel  [NUM_TRACKS][3];

  // Measurement and search bookkeeping
  logic [COORD_W-1:0]       meas [3];
  logic [ID_W-1:0]          idx;
  logic [ID_W-1:0]          best_idx;
  logic [ID_W-1:0]          free_idx;
  logic                     best_found;
  logic                     free_found;
  logic [COORD_W-1:0]       best_dist;
  logic                     tick_pending;
  logic                     run;

  logic [COORD_W-1:0]       cur_dist;
  logic signed [VEL_W-1:0]  upd_vel  [3];
  logic [COORD_W-1:0]       upd_pred [3];

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // pos + vel clamped to [0, 2^COORD_W-1]; two guard bits catch both ends.
  function automatic logic [COORD_W-1:0] sat_pred(input logic [COORD_W-1:0]      p,
                                                  input logic signed [VEL_W-1:0] v);
    logic signed [COORD_W+1:0] s;
    s = $signed({2'b00, p}) + $signed({v[VEL_W-1], v});
    if (s[COORD_W+1])    return '0;
    else if (s[COORD_W]) return '1;
    else                 return s[COORD_W-1:0];
  endfunction

  function automatic logic is_fast(input logic signed [VEL_W-1:0] v);
    logic [VEL_W-1:0] m;
    m = v[VEL_W-1] ? VEL_W'(-v) : VEL_W'(v);
    return m >= {1'b0, VELOCITY_THRESHOLD};
  endfunction

  // A tick seen this very cycle already blocks acceptance so it is serviced first.
  assign in_ready = run && (state == IDLE) && lock_active && !tick_pending && !frame_tick;

  always_comb begin
    cur_dist = max3(abs_diff(meas[0], pred[idx][0]),
                    abs_diff(meas[1], pred[idx][1]),
                    abs_diff(meas[2], pred[idx][2]));
  end

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      upd_vel[a]  = $signed({1'b0, meas[a]}) - $signed({1'b0, pos[best_idx][a]});
      upd_pred[a] = sat_pred(meas[a], upd_vel[a]);
    end
  end

  // Slot contents cannot change while a report is held, so this is stable.
  always_comb begin
    target_moving = 1'b0;
    if (out_valid) begin
      for (int a = 0; a < 3; a++) begin
        if (is_fast(vel[trk_id][a])) target_moving = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!lock_active && |slot_valid)      state_nxt = FLUSH;
        else if (tick_pending || frame_tick)  state_nxt = TICK;
        else if (in_valid && in_ready)        state_nxt = SEARCH;
      end
      TICK:    state_nxt = IDLE;
      FLUSH:   state_nxt = IDLE;
      SEARCH:  if (idx == LAST_IDX) state_nxt = UPDATE;
      UPDATE:  state_nxt = (best_found || free_found) ? REPORT : IDLE;
      REPORT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      run          <= 1'b0;
      tick_pending <= 1'b0;
      idx          <= '0;
      best_idx     <= '0;
      free_idx     <= '0;
      best_found   <= 1'b0;
      free_found   <= 1'b0;
      best_dist    <= '0;
      slot_valid   <= '0;
      slot_hit     <= '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        miss[i] <= '0;
        for (int a = 0; a < 3; a++) begin
          pos[i][a]  <= '0;
          pred[i][a] <= '0;
          vel[i][a]  <= '0;
        end
      end
      for (int a = 0; a < 3; a++) meas[a] <= '0;
      out_valid   <= 1'b0;
      trk_id      <= '0;
      x_curr      <= '0;
      y_curr      <= '0;
      z_curr      <= '0;
      x_pred      <= '0;
      y_pred      <= '0;
      z_pred      <= '0;
      new_track   <= 1'b0;
      active_mask <= '0;
      overflow    <= 1'b0;
    end else begin
      run         <= 1'b1;
      state       <= state_nxt;
      overflow    <= 1'b0;
      active_mask <= slot_valid;

      // A tick landing on the cycle its predecessor is serviced stays pending.
      if (frame_tick)                          tick_pending <= 1'b1;
      else if (state == TICK || state == FLUSH) tick_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (state_nxt == SEARCH) begin
            meas[0]    <= x_in;
            meas[1]    <= y_in;
            meas[2]    <= z_in;
            idx        <= '0;
            best_found <= 1'b0;
            free_found <= 1'b0;
          end
        end

        TICK: begin
          for (int i = 0; i < NUM_TRACKS; i++) begin
            if (slot_valid[i]) begin
              if (slot_hit[i]) begin
                miss[i] <= '0;
              end else begin
                miss[i] <= miss[i] + 1'b1;
                if (miss[i] == MISS_LAST) slot_valid[i] <= 1'b0;
              end
            end
          end
          slot_hit <= '0;
        end

        FLUSH: begin
          slot_valid <= '0;
          slot_hit   <= '0;
          for (int i = 0; i < NUM_TRACKS; i++) miss[i] <= '0;
        end

        SEARCH: begin
          if (slot_valid[idx] && cur_dist <= GATE &&
              (!best_found || cur_dist < best_dist)) begin
            best_found <= 1'b1;
            best_idx   <= idx;
            best_dist  <= cur_dist;
          end
          if (!slot_valid[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + 1'b1;
        end

        UPDATE: begin
          if (best_found) begin
            for (int a = 0; a < 3; a++) begin
              vel[best_idx][a]  <= upd_vel[a];
              pred[best_idx][a] <= upd_pred[a];
              pos[best_idx][a]  <= meas[a];
            end
            slot_hit[best_idx] <= 1'b1;
            trk_id    <= best_idx;
            new_track <= 1'b0;
            x_pred    <= upd_pred[0];
            y_pred    <= upd_pred[1];
            z_pred    <= upd_pred[2];
            out_valid <= 1'b1;
          end else if (free_found) begin
            for (int a = 0; a < 3; a++) begin
              vel[free_idx][a]  <= '0;
              pred[free_idx][a] <= meas[a];
              pos[free_idx][a]  <= meas[a];
            end
            slot_valid[free_idx] <= 1'b1;
            slot_hit[free_idx]   <= 1'b1;
            miss[free_idx]       <= '0;
            trk_id    <= free_idx;
            new_track <= 1'b1;
            x_pred    <= meas[0];
            y_pred    <= meas[1];
            z_pred    <= meas[2];
            out_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
          if (best_found || free_found) begin
            x_curr <= meas[0];
            y_curr <= meas[1];
            z_curr <= meas[2];
          end
        end

        REPORT: begin
          if (out_ready) out_valid <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule
